// File: rtl/dual_port_mem_arbiter_if.sv
// HLS master memory bus, two channels packed side by side (ch0 in the low field).
//   Mout_oe_ram        per-channel read request, held until M_DataRdy
//   Mout_we_ram        per-channel write request, held until M_DataRdy
//   Mout_addr_ram      per-channel address
//   Mout_Wdata_ram     per-channel write data
//   Mout_data_ram_size per-channel access size in bits
//   M_Rdata_ram        per-channel read data (only the serviced field is nonzero)
//   M_DataRdy          per-channel one-cycle completion pulse
// master = accelerator side, slave = arbiter side.
interface dual_port_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    logic [1:0]          Mout_oe_ram;
    logic [1:0]          Mout_we_ram;
    logic [2*ADDR_W-1:0] Mout_addr_ram;
    logic [2*DATA_W-1:0] Mout_Wdata_ram;
    logic [2*SIZE_W-1:0] Mout_data_ram_size;
    logic [2*DATA_W-1:0] M_Rdata_ram;
    logic [1:0]          M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/dual_port_mem_arbiter.sv
// Round-robin arbiter folding the two HLS memory channels onto one
// single-port synchronous RAM with configurable read/write latency.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   bus            HLS channel bus (slave modport)
//   mem_en/mem_we  RAM strobe and write enable (mem_en is a one-cycle pulse)
//   mem_addr/mem_wdata/mem_wmask  RAM address, write data, bit write mask
//   mem_rdata      RAM read data
//   err_conflict   sticky: a channel asserted oe and we together while idle
//
// state | meaning
// IDLE  | sample requests, grant one channel, latch its access
// ISSUE | drive the RAM strobe for one cycle, load the latency counter
// WAIT  | count down the RAM latency, capture read data on the last count
// DONE  | pulse M_DataRdy for the granted channel, present read data
module dual_port_mem_arbiter #(
    parameter int ADDR_W          = 12,
    parameter int DATA_W          = 8,
    parameter int SIZE_W          = 4,
    parameter int MEM_DELAY_READ  = 2,
    parameter int MEM_DELAY_WRITE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    dual_port_mem_arbiter_if.slave bus,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err_conflict
);

    localparam logic [3:0] RD_LOAD = 4'(MEM_DELAY_READ - 1);
    localparam logic [3:0] WR_LOAD = 4'(MEM_DELAY_WRITE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [SIZE_W-1:0]   size_q, size_d;

    logic [1:0]          req;
    logic [1:0]          conflict;
    logic                gnt_sel;
    logic [3:0]          load;
    logic [DATA_W-1:0]   wmask;

    // A channel with both oe and we is malformed and does not count as requesting.
    assign conflict = bus.Mout_oe_ram & bus.Mout_we_ram;
    assign req      = bus.Mout_oe_ram ^ bus.Mout_we_ram;
    assign load     = we_q ? WR_LOAD : RD_LOAD;

    always_comb begin
        gnt_sel = 1'b0;
        if (req == 2'b10)
            gnt_sel = 1'b1;
        else if (req == 2'b11)
            gnt_sel = ~last_q;
    end

    // Sizes at or beyond the data width write every bit.
    always_comb begin
        wmask = '1;
        if (32'(size_q) < DATA_W)
            wmask = (DATA_W'(1) << size_q) - DATA_W'(1);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req) state_d = S_ISSUE;
            S_ISSUE: state_d = (load == 4'd0) ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt_q <= 4'd1) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q | ((state_q == S_IDLE) && (|conflict));
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = gnt_sel;
                    last_d  = gnt_sel;
                    we_d    = gnt_sel ? bus.Mout_we_ram[1] : bus.Mout_we_ram[0];
                    addr_d  = gnt_sel ? bus.Mout_addr_ram[2*ADDR_W-1:ADDR_W]
                                      : bus.Mout_addr_ram[ADDR_W-1:0];
                    wdata_d = gnt_sel ? bus.Mout_Wdata_ram[2*DATA_W-1:DATA_W]
                                      : bus.Mout_Wdata_ram[DATA_W-1:0];
                    size_d  = gnt_sel ? bus.Mout_data_ram_size[2*SIZE_W-1:SIZE_W]
                                      : bus.Mout_data_ram_size[SIZE_W-1:0];
                end
            end
            S_ISSUE: cnt_d = load;
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if ((cnt_q == 4'd1) && !we_q)
                    rdata_d = mem_rdata;
            end
            default: ;
        endcase
    end

    // last_q resets to 1 so that channel 0 wins the first contested grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from state only, so reset clears them immediately.
    always_comb begin
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wmask       = '0;
        bus.M_DataRdy   = 2'b00;
        bus.M_Rdata_ram = '0;
        case (state_q)
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask;
            end
            S_DONE: begin
                bus.M_DataRdy[gnt_q] = 1'b1;
                if (!we_q) begin
                    if (gnt_q)
                        bus.M_Rdata_ram[2*DATA_W-1:DATA_W] = rdata_q;
                    else
                        bus.M_Rdata_ram[DATA_W-1:0] = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign err_conflict = err_q;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
module tb_dual_port_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SW = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic rst4;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- main DUT (read delay 2, write delay 1) ----------------
    dual_port_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) bus ();
    logic          mem_en, mem_we, err_conflict;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_wmask, mem_rdata;

    dual_port_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
                            .MEM_DELAY_READ(2), .MEM_DELAY_WRITE(1)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .err_conflict(err_conflict)
    );

    // ---------------- second DUT (read delay 4) for the reset-abort case ----------------
    dual_port_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) bus4 ();
    logic          mem_en4, mem_we4, err4;
    logic [AW-1:0] mem_addr4;
    logic [DW-1:0] mem_wdata4, mem_wmask4, mem_rdata4;

    dual_port_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
                            .MEM_DELAY_READ(4), .MEM_DELAY_WRITE(1)) dut4 (
        .clock(clock), .reset(rst4), .bus(bus4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_wmask(mem_wmask4), .mem_rdata(mem_rdata4),
        .err_conflict(err4)
    );

    // ---------------- RAM models: read data registered on the strobe and held ----------------
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] ram  [0:4095] = '{default: '0};
    logic [DW-1:0] ram4 [0:4095] = '{default: '0};

    always @(posedge clock) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            else        mem_rdata <= ram[mem_addr];
        end
    end

    always @(posedge clock) begin
        if (pl_en) ram4[pl_addr] <= pl_data;
        else if (mem_en4) begin
            if (mem_we4) ram4[mem_addr4] <= (ram4[mem_addr4] & ~mem_wmask4) | (mem_wdata4 & mem_wmask4);
            else         mem_rdata4 <= ram4[mem_addr4];
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [1:0] rdy; logic [15:0] data; } resp_t;
    typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] wmask; } macc_t;
    resp_t exp_resp[$];
    macc_t exp_mem[$];
    int    last_mem_cyc = 0;

    always @(negedge clock) begin : resp_mon
        resp_t e;
        if (!reset) begin
            if (bus.M_DataRdy != 2'b00) begin
                if (exp_resp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rdy: got %b expected none (cycle %0d)", bus.M_DataRdy, cyc);
                end else begin
                    e = exp_resp.pop_front();
                    check("rdy_channel", 32'(bus.M_DataRdy), 32'(e.rdy));
                    check("rdata", 32'(bus.M_Rdata_ram), 32'(e.data));
                end
            end else begin
                check("rdata_idle_zero", 32'(bus.M_Rdata_ram), 32'h0);
            end
        end
    end

    always @(negedge clock) begin : mem_mon
        macc_t e;
        if (!reset && mem_en) begin
            last_mem_cyc = cyc;
            if (exp_mem.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_mem_en: addr %0h expected none (cycle %0d)", mem_addr, cyc);
            end else begin
                e = exp_mem.pop_front();
                check("mem_we", 32'(mem_we), 32'(e.we));
                check("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we) begin
                    check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                    check("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic set_req(input int ch, input logic oe, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] sz);
        bus.Mout_oe_ram[ch]                 = oe;
        bus.Mout_we_ram[ch]                 = we;
        bus.Mout_addr_ram[ch*AW +: AW]      = a;
        bus.Mout_Wdata_ram[ch*DW +: DW]     = d;
        bus.Mout_data_ram_size[ch*SW +: SW] = sz;
    endtask

    task automatic wait_rdy(input int ch, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.M_DataRdy[ch]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL timeout_rdy_ch%0d: no DataRdy within 40 cycles", ch);
        end
    endtask

    task automatic txn(input int ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] sz, input logic [DW-1:0] msk, input logic [15:0] exp_data,
                       input int lat);
        macc_t m;
        resp_t r;
        int    t0, at;
        m.we = we; m.addr = a; m.wdata = d; m.wmask = msk;
        exp_mem.push_back(m);
        r.rdy  = (ch == 0) ? 2'b01 : 2'b10;
        r.data = we ? 16'h0000 : exp_data;
        exp_resp.push_back(r);
        @(posedge clock); #1;
        t0 = cyc;
        set_req(ch, !we, we, a, d, sz);
        wait_rdy(ch, at);
        check("latency", 32'(at - t0), 32'(lat));
        check("mem_en_latency", 32'(last_mem_cyc - t0), 32'd1);
        @(posedge clock); #1;
        set_req(ch, 1'b0, 1'b0, '0, '0, '0);
    endtask

    int pulses4 = 0;
    int mems4   = 0;
    always @(negedge clock) begin
        if (|bus4.M_DataRdy) pulses4++;
        if (mem_en4)         mems4++;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, n, p, m, at;
        macc_t mm;
        resp_t rr;

        reset = 1'b1; rst4 = 1'b1;
        bus.Mout_oe_ram = '0; bus.Mout_we_ram = '0; bus.Mout_addr_ram = '0;
        bus.Mout_Wdata_ram = '0; bus.Mout_data_ram_size = '0;
        bus4.Mout_oe_ram = '0; bus4.Mout_we_ram = '0; bus4.Mout_addr_ram = '0;
        bus4.Mout_Wdata_ram = '0; bus4.Mout_data_ram_size = '0;

        // reset state
        @(negedge clock);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wmask", 32'(mem_wmask), 0);
        check("rst_rdy", 32'(bus.M_DataRdy), 0);
        check("rst_rdata", 32'(bus.M_Rdata_ram), 0);
        check("rst_err", 32'(err_conflict), 0);

        preload(12'h010, 8'hA5);
        preload(12'h020, 8'h00);
        preload(12'h030, 8'h00);
        preload(12'h031, 8'h55);
        preload(12'h032, 8'h00);
        preload(12'h040, 8'h11);
        preload(12'h041, 8'h22);
        preload(12'h050, 8'h5A);
        preload(12'h051, 8'h6B);
        @(posedge clock); #1;
        reset = 1'b0; rst4 = 1'b0;
        repeat (2) @(posedge clock); #1;

        // ch0 read, read latency 3
        txn(0, 1'b0, 12'h010, 8'h00, 4'd8, 8'h00, 16'h00A5, 3);

        // ch1 write then readback into the high field
        txn(1, 1'b1, 12'h020, 8'h3C, 4'd8, 8'hFF, 16'h0000, 2);
        txn(1, 1'b0, 12'h020, 8'h00, 4'd8, 8'h00, 16'h3C00, 3);

        // partial, empty and oversize write masks
        txn(0, 1'b1, 12'h030, 8'hFF, 4'd4, 8'h0F, 16'h0000, 2);
        txn(0, 1'b0, 12'h030, 8'h00, 4'd8, 8'h00, 16'h000F, 3);
        txn(0, 1'b1, 12'h031, 8'hFF, 4'd0, 8'h00, 16'h0000, 2);
        txn(0, 1'b0, 12'h031, 8'h00, 4'd8, 8'h00, 16'h0055, 3);
        txn(1, 1'b1, 12'h032, 8'hC3, 4'd12, 8'hFF, 16'h0000, 2);
        txn(1, 1'b0, 12'h032, 8'h00, 4'd8, 8'h00, 16'hC300, 3);

        // both channels reading continuously: grants alternate from ch0, pulses 4 apart
        for (int i = 0; i < 8; i++) begin
            mm.we = 1'b0; mm.addr = (i % 2 == 0) ? 12'h040 : 12'h041; mm.wdata = '0; mm.wmask = '0;
            exp_mem.push_back(mm);
            rr.rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
            rr.data = (i % 2 == 0) ? 16'h0011 : 16'h2200;
            exp_resp.push_back(rr);
        end
        @(posedge clock); #1;
        t0 = cyc;
        set_req(0, 1'b1, 1'b0, 12'h040, 8'h00, 4'd8);
        set_req(1, 1'b1, 1'b0, 12'h041, 8'h00, 4'd8);
        n = 0; p = -1;
        for (int i = 0; i < 80 && n < 8; i++) begin
            @(negedge clock);
            if (|bus.M_DataRdy) begin
                if (n == 0) check("rr_first_latency", 32'(cyc - t0), 32'd3);
                else        check("rr_pulse_spacing", 32'(cyc - p), 32'd4);
                p = cyc;
                n++;
            end
        end
        check("rr_pulse_count", 32'(n), 32'd8);
        @(posedge clock); #1;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clock); #1;

        // conflict on ch0 while ch1 reads: only ch1 serviced, flag sticky until reset
        mm.we = 1'b0; mm.addr = 12'h041; mm.wdata = '0; mm.wmask = '0;
        exp_mem.push_back(mm);
        rr.rdy = 2'b10; rr.data = 16'h2200;
        exp_resp.push_back(rr);
        @(posedge clock); #1;
        t0 = cyc;
        set_req(0, 1'b1, 1'b1, 12'h010, 8'h77, 4'd8);
        set_req(1, 1'b1, 1'b0, 12'h041, 8'h00, 4'd8);
        wait_rdy(1, at);
        check("conflict_ch1_latency", 32'(at - t0), 32'd3);
        check("err_conflict_set", 32'(err_conflict), 32'd1);
        @(posedge clock); #1;
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (6) @(negedge clock);
        check("err_conflict_held", 32'(err_conflict), 32'd1);
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        check("err_conflict_sticky", 32'(err_conflict), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("err_conflict_cleared", 32'(err_conflict), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // reset in WAIT of a delay-4 read aborts it
        @(posedge clock); #1;
        bus4.Mout_oe_ram[0] = 1'b1;
        bus4.Mout_addr_ram[AW-1:0] = 12'h050;
        bus4.Mout_data_ram_size[SW-1:0] = 4'd8;
        repeat (3) @(posedge clock); #1;
        check("abort_issued", 32'(mems4), 32'd1);
        rst4 = 1'b1;
        #1;
        check("abort_mem_en", 32'(mem_en4), 0);
        check("abort_rdy", 32'(bus4.M_DataRdy), 0);
        check("abort_rdata", 32'(bus4.M_Rdata_ram), 0);
        check("abort_mem_addr", 32'(mem_addr4), 0);
        bus4.Mout_oe_ram = '0;
        p = pulses4; m = mems4;
        repeat (3) @(posedge clock); #1;
        rst4 = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_no_rdy", 32'(pulses4 - p), 32'd0);
        check("abort_no_strobe", 32'(mems4 - m), 32'd0);

        @(posedge clock); #1;
        t0 = cyc;
        bus4.Mout_oe_ram = 2'b11;
        bus4.Mout_addr_ram = {12'h051, 12'h050};
        bus4.Mout_data_ram_size = {4'd8, 4'd8};
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (|bus4.M_DataRdy) begin at = cyc; break; end
        end
        check("post_reset_grant", 32'(bus4.M_DataRdy), 32'h1);
        check("post_reset_data", 32'(bus4.M_Rdata_ram), 32'h005A);
        check("post_reset_latency", 32'(at - t0), 32'd5);
        @(posedge clock); #1;
        bus4.Mout_oe_ram[0] = 1'b0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (|bus4.M_DataRdy) begin at = cyc; break; end
        end
        check("post_reset_ch1_grant", 32'(bus4.M_DataRdy), 32'h2);
        check("post_reset_ch1_data", 32'(bus4.M_Rdata_ram), 32'h6B00);
        @(posedge clock); #1;
        bus4.Mout_oe_ram = '0;

        repeat (4) @(posedge clock);
        check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
        check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
